// File: rtl/pixel_link_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : pixel_link_pkg                                         |
// | Description : Shared beat/word types for the 11-bit pixel link.      |
// |               Imported by both the tx and the future rx side.        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package pixel_link_pkg;

  localparam int c_pixel_w = 16;
  // FIFO entry is {sof, pixel}
  localparam int c_fifo_w  = c_pixel_w + 1;

  typedef enum logic [1:0] {
    BEAT_IDLE = 2'b00,
    BEAT_SOF  = 2'b01,
    BEAT_HI   = 2'b10,
    BEAT_LO   = 2'b11
  } beat_t;

  typedef struct packed {
    beat_t      kind;
    logic       par;
    logic [7:0] data;
  } link_word_t;

  typedef enum logic [1:0] {
    TX_TRAIN = 2'd0,
    TX_IDLE  = 2'd1,
    TX_HI    = 2'd2,
    TX_LO    = 2'd3
  } tx_state_t;

  // Build a link word; parity makes the payload-plus-parity count odd.
  function automatic link_word_t make_word(input beat_t kind, input logic [7:0] data);
    link_word_t w;
    w.kind = kind;
    w.par  = ~^data;
    w.data = data;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_link_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : pixel_link_if                                          |
// | Description : Pixel stream input and link output bundle of the tx.  |
// |               slave = transmitter, master = pixel source / board.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface pixel_link_if;
  logic        valid_in;
  logic [15:0] pixel_in;
  logic        sof_in;
  logic        ready_out;
  logic [10:0] link_data_out;
  logic        link_clk_out;
  logic        link_lock_out;

  modport master (
    output valid_in, pixel_in, sof_in,
    input  ready_out, link_data_out, link_clk_out, link_lock_out
  );

  modport slave (
    input  valid_in, pixel_in, sof_in,
    output ready_out, link_data_out, link_clk_out, link_lock_out
  );
endinterface
`default_nettype wire

// File: rtl/pixel_link_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : pixel_link_fifo                                        |
// | Description : Synchronous first-word-fall-through FIFO. Pointers     |
// |               carry one extra MSB to tell full from empty.           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module pixel_link_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 16
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_push,
  input  wire logic [WIDTH-1:0] i_wdata,
  input  wire logic             i_pop,
  output logic      [WIDTH-1:0] o_rdata,
  output logic                  o_empty,
  output logic                  o_full_next
);

  localparam int c_aw = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [c_aw:0]    wr_ptr_q, wr_ptr_d;
  logic [c_aw:0]    rd_ptr_q, rd_ptr_d;
  logic             w_full;
  logic             w_wr_en;
  logic             w_rd_en;

  // Flags and next pointers; pushes into a full FIFO and pops from an empty one are ignored.
  always_comb begin
    o_empty     = (wr_ptr_q == rd_ptr_q);
    w_full      = (wr_ptr_q[c_aw] != rd_ptr_q[c_aw]) &&
                  (wr_ptr_q[c_aw-1:0] == rd_ptr_q[c_aw-1:0]);
    w_wr_en     = i_push & ~w_full;
    w_rd_en     = i_pop & ~o_empty;
    wr_ptr_d    = wr_ptr_q + (c_aw+1)'(w_wr_en);
    rd_ptr_d    = rd_ptr_q + (c_aw+1)'(w_rd_en);
    o_full_next = (wr_ptr_d[c_aw] != rd_ptr_d[c_aw]) &&
                  (wr_ptr_d[c_aw-1:0] == rd_ptr_d[c_aw-1:0]);
    o_rdata     = mem_q[rd_ptr_q[c_aw-1:0]];
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      mem_q[wr_ptr_q[c_aw-1:0]] <= i_wdata;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pixel_link_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : pixel_link_tx                                          |
// | Description : Transmit side of the 11-bit pixel link. Buffers RGB565 |
// |               pixels and sends them as SOF/HI/LO beats with a        |
// |               forwarded clock and a lock line.                       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module pixel_link_tx
  import pixel_link_pkg::*;
#(
  parameter int         CLK_DIV     = 4,
  parameter int         FIFO_DEPTH  = 16,
  parameter int         TRAIN_BEATS = 32,
  parameter logic [7:0] SOF_PAYLOAD = 8'hA5
) (
  input wire logic    clk,
  input wire logic    rst,
  pixel_link_if.slave link
);

  localparam int                   c_div_w      = $clog2(CLK_DIV);
  localparam int                   c_half       = CLK_DIV / 2;
  localparam int                   c_train_w    = $clog2(TRAIN_BEATS + 1);
  localparam logic [c_div_w-1:0]   c_div_last   = c_div_w'(CLK_DIV - 1);
  localparam logic [c_train_w-1:0] c_train_last = c_train_w'(TRAIN_BEATS - 1);

  logic [c_div_w-1:0]   div_q, div_d;
  logic                 link_clk_q, link_clk_d;
  tx_state_t            state_q, state_d;
  logic [c_train_w-1:0] train_cnt_q, train_cnt_d;
  link_word_t           word_q, word_d;
  logic                 lock_q, lock_d;
  logic                 ready_q, ready_d;
  logic [15:0]          held_q, held_d;

  logic                 w_tick;
  logic                 w_push;
  logic                 w_pop;
  logic [c_fifo_w-1:0]  w_head;
  logic                 w_empty;
  logic                 w_full_next;

  // w_tick marks the last cycle of a beat: decisions taken here become
  // visible while the counter is 0, giving c_half cycles of setup before
  // the forwarded clock rises.
  assign w_tick = (div_q == c_div_last);
  assign w_push = link.valid_in & ready_q;

  pixel_link_fifo #(
    .WIDTH (c_fifo_w),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_wdata     ({link.sof_in, link.pixel_in}),
    .i_pop       (w_pop),
    .o_rdata     (w_head),
    .o_empty     (w_empty),
    .o_full_next (w_full_next)
  );

  // Beat divider and forwarded clock; the clock flop tracks the next count so it is high for the upper half.
  always_comb begin
    div_d      = w_tick ? '0 : div_q + c_div_w'(1);
    link_clk_d = (int'(div_d) >= c_half);
    ready_d    = ~w_full_next;
  end

  // Transmit FSM: advances only at beat boundaries; HI/LO come from the held pixel so the FIFO is never needed mid-pixel.
  always_comb begin
    state_d     = state_q;
    train_cnt_d = train_cnt_q;
    word_d      = word_q;
    lock_d      = lock_q;
    held_d      = held_q;
    w_pop       = 1'b0;
    if (w_tick) begin
      case (state_q)
        TX_TRAIN: begin
          word_d = make_word(BEAT_IDLE, 8'h00);
          if (train_cnt_q == c_train_last) begin
            lock_d  = 1'b1;
            state_d = TX_IDLE;
          end else begin
            train_cnt_d = train_cnt_q + c_train_w'(1);
          end
        end
        TX_IDLE: begin
          if (w_empty) begin
            word_d = make_word(BEAT_IDLE, 8'h00);
          end else begin
            w_pop  = 1'b1;
            held_d = w_head[15:0];
            if (w_head[16]) begin
              word_d  = make_word(BEAT_SOF, SOF_PAYLOAD);
              state_d = TX_HI;
            end else begin
              word_d  = make_word(BEAT_HI, w_head[15:8]);
              state_d = TX_LO;
            end
          end
        end
        TX_HI: begin
          word_d  = make_word(BEAT_HI, held_q[15:8]);
          state_d = TX_LO;
        end
        TX_LO: begin
          word_d  = make_word(BEAT_LO, held_q[7:0]);
          state_d = TX_IDLE;
        end
        default: ;
      endcase
    end
  end

  // State and output registers; reset drops any partial pixel and restarts training.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q       <= '0;
      link_clk_q  <= 1'b0;
      state_q     <= TX_TRAIN;
      train_cnt_q <= '0;
      word_q      <= make_word(BEAT_IDLE, 8'h00);
      lock_q      <= 1'b0;
      ready_q     <= 1'b0;
      held_q      <= '0;
    end else begin
      div_q       <= div_d;
      link_clk_q  <= link_clk_d;
      state_q     <= state_d;
      train_cnt_q <= train_cnt_d;
      word_q      <= word_d;
      lock_q      <= lock_d;
      ready_q     <= ready_d;
      held_q      <= held_d;
    end
  end

  assign link.ready_out     = ready_q;
  assign link.link_data_out = word_q;
  assign link.link_clk_out  = link_clk_q;
  assign link.link_lock_out = lock_q;

endmodule
`default_nettype wire

// File: tb/tb_pixel_link_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_pixel_link_tx                                       |
// | Description : Directed and random checks of pixel_link_tx with the   |
// |               default parameters. Beats are captured on each rising  |
// |               edge of the forwarded clock as {lock, data}.           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_pixel_link_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pixel_link_if lif ();

  pixel_link_tx #(
    .CLK_DIV     (4),
    .FIFO_DEPTH  (16),
    .TRAIN_BEATS (32),
    .SOF_PAYLOAD (8'hA5)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .link (lif)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [11:0] beats [$];
  logic        prev_lclk = 1'b0;

  // Beat monitor: record {lock, data} on each forwarded-clock rising edge.
  always @(negedge clk) begin
    if (lif.link_clk_out === 1'b1 && prev_lclk === 1'b0)
      beats.push_back({lif.link_lock_out, lif.link_data_out});
    prev_lclk <= lif.link_clk_out;
  end

  function automatic logic [10:0] mk_beat(input logic [1:0] k, input logic [7:0] d);
    return {k, ~^d, d};
  endfunction

  function automatic logic [15:0] pix_of(input int k);
    return 16'(k * 16'h0907) ^ 16'h3C5A;
  endfunction

  task automatic push_pixel(input logic [15:0] p, input logic s, output bit ok);
    ok = 1'b0;
    lif.valid_in = 1'b1;
    lif.pixel_in = p;
    lif.sof_in   = s;
    for (int i = 0; i < 500; i++) begin
      if (lif.ready_out === 1'b1) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    lif.valid_in = 1'b0;
    lif.sof_in   = 1'b0;
  endtask

  task automatic test_reset();
    logic s [12];
    int   ones;
    int   trans;
    bit   per_ok;
    int   bad;
    lif.valid_in = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_total++; if (lif.link_data_out !== 11'h100) $display("FAIL reset_data: got %h want 100", lif.link_data_out); else n_pass++;
    n_total++; if (lif.link_clk_out !== 1'b0) $display("FAIL reset_lclk: got %b want 0", lif.link_clk_out); else n_pass++;
    n_total++; if (lif.link_lock_out !== 1'b0) $display("FAIL reset_lock: got %b want 0", lif.link_lock_out); else n_pass++;
    n_total++; if (lif.ready_out !== 1'b0) $display("FAIL reset_ready: got %b want 0", lif.ready_out); else n_pass++;
    rst = 1'b0;
    beats.delete();
    @(negedge clk);
    n_total++; if (lif.ready_out !== 1'b1) $display("FAIL ready_after_reset: got %b want 1", lif.ready_out); else n_pass++;
    for (int i = 0; i < 12; i++) begin
      s[i] = lif.link_clk_out;
      @(negedge clk);
    end
    per_ok = 1'b1;
    for (int i = 0; i < 8; i++) if (s[i] !== s[i+4]) per_ok = 1'b0;
    ones = 0; trans = 0;
    for (int i = 0; i < 4; i++) begin
      if (s[i] === 1'b1) ones++;
      if (s[i] !== s[(i+1)%4]) trans++;
    end
    n_total++; if (!per_ok) $display("FAIL lclk_period: samples not periodic with 4 cycles, want period 4"); else n_pass++;
    n_total++; if (ones != 2 || trans != 2) $display("FAIL lclk_duty: got %0d high cycles %0d edges per period, want 2 and 2", ones, trans); else n_pass++;
    for (int c = 0; c < 400 && beats.size() < 33; c++) @(negedge clk);
    n_total++;
    if (beats.size() < 33) begin
      $display("FAIL train_timeout: got %0d beats want 33", beats.size());
    end else begin
      n_pass++;
      bad = 0;
      for (int i = 0; i < 32; i++) if (beats[i] !== 12'h100) bad++;
      n_total++; if (bad != 0) $display("FAIL train_idle: got %0d bad beats want 0", bad); else n_pass++;
      n_total++; if (beats[32] !== 12'h900) $display("FAIL train_lock: got %h want 900", beats[32]); else n_pass++;
    end
  endtask

  task automatic test_frame();
    logic [11:0] exp [6];
    bit          ok0, ok1;
    int          f;
    exp[0] = 12'hBA5; exp[1] = 12'hCF8; exp[2] = 12'hE1F;
    exp[3] = 12'hC07; exp[4] = 12'hEE0; exp[5] = 12'h900;
    beats.delete();
    push_pixel(16'hF81F, 1'b1, ok0);
    push_pixel(16'h07E0, 1'b0, ok1);
    n_total++; if (!(ok0 && ok1)) $display("FAIL frame_push: got accepted %b%b want 11", ok0, ok1); else n_pass++;
    repeat (60) @(negedge clk);
    f = -1;
    foreach (beats[i]) if (f < 0 && beats[i][10:0] !== 11'h100) f = i;
    n_total++;
    if (f < 0 || f + 6 > beats.size()) begin
      $display("FAIL frame_len: got start %0d size %0d want 6 beats", f, beats.size());
    end else begin
      n_pass++;
      for (int i = 0; i < 6; i++) begin
        n_total++;
        if (beats[f+i] !== exp[i]) $display("FAIL frame_beat%0d: got %h want %h", i, beats[f+i], exp[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_latency();
    bit found;
    logic prev;
    repeat (40) @(negedge clk);
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      prev = lif.link_clk_out;
      @(negedge clk);
      if (prev === 1'b1 && lif.link_clk_out === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    n_total++; if (!found) $display("FAIL latency_boundary: got no boundary want one"); else n_pass++;
    @(negedge clk);
    lif.valid_in = 1'b1; lif.pixel_in = 16'hABCD; lif.sof_in = 1'b0;
    n_total++; if (lif.ready_out !== 1'b1) $display("FAIL latency_ready: got %b want 1", lif.ready_out); else n_pass++;
    @(negedge clk);
    lif.valid_in = 1'b0;
    @(negedge clk);
    n_total++; if (lif.link_data_out !== 11'h100) $display("FAIL latency_early: got %h want 100", lif.link_data_out); else n_pass++;
    @(negedge clk);
    n_total++; if (lif.link_data_out !== 11'h4AB) $display("FAIL latency_hi: got %h want 4ab", lif.link_data_out); else n_pass++;
    repeat (4) @(negedge clk);
    n_total++; if (lif.link_data_out !== 11'h6CD) $display("FAIL latency_lo: got %h want 6cd", lif.link_data_out); else n_pass++;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_full();
    int          idx;
    logic        acc;
    logic [11:0] exp [$];
    int          nonidle;
    int          f;
    int          mism;
    rst = 1'b1; lif.valid_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    beats.delete();
    idx = 0;
    lif.valid_in = 1'b1;
    for (int cyc = 0; cyc < 600 && idx < 17; cyc++) begin
      lif.pixel_in = pix_of(idx);
      lif.sof_in   = (idx == 0);
      acc = lif.ready_out;
      @(negedge clk);
      if (acc === 1'b1) idx++;
      if (cyc == 40) begin
        n_total++; if (idx != 16) $display("FAIL full_accepted: got %0d want 16", idx); else n_pass++;
        n_total++; if (lif.ready_out !== 1'b0) $display("FAIL full_ready_low: got %b want 0", lif.ready_out); else n_pass++;
        n_total++; if (lif.link_lock_out !== 1'b0) $display("FAIL full_still_training: got %b want 0", lif.link_lock_out); else n_pass++;
      end
    end
    lif.valid_in = 1'b0; lif.sof_in = 1'b0;
    n_total++; if (idx != 17) $display("FAIL full_last_accepted: got %0d want 17", idx); else n_pass++;
    for (int k = 0; k < 17; k++) begin
      if (k == 0) exp.push_back({1'b1, mk_beat(2'b01, 8'hA5)});
      exp.push_back({1'b1, mk_beat(2'b10, pix_of(k) >> 8)});
      exp.push_back({1'b1, mk_beat(2'b11, pix_of(k) & 16'h00FF)});
    end
    for (int c = 0; c < 1000; c++) begin
      nonidle = 0;
      foreach (beats[i]) if (beats[i][10:9] != 2'b00) nonidle++;
      if (nonidle >= 35) break;
      @(negedge clk);
    end
    f = -1;
    foreach (beats[i]) if (f < 0 && beats[i][10:9] != 2'b00) f = i;
    n_total++;
    if (f < 0 || f + 35 > beats.size()) begin
      $display("FAIL full_drain: got start %0d size %0d want 35 beats", f, beats.size());
    end else begin
      n_pass++;
      mism = 0;
      for (int i = 0; i < 35; i++) if (beats[f+i] !== exp[i]) mism++;
      n_total++; if (mism != 0) $display("FAIL full_order: got %0d wrong beats want 0", mism); else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [10:0] exp [$];
    logic [10:0] got [$];
    logic [15:0] p;
    logic        s;
    bit          ok;
    int          perr, lerr, nsof, mism, push_fail;
    beats.delete();
    push_fail = 0;
    for (int k = 0; k < 1000; k++) begin
      p = 16'($urandom);
      s = (k % 25 == 0);
      push_pixel(p, s, ok);
      if (!ok) begin
        push_fail++;
        break;
      end
      if (s) exp.push_back(mk_beat(2'b01, 8'hA5));
      exp.push_back(mk_beat(2'b10, p[15:8]));
      exp.push_back(mk_beat(2'b11, p[7:0]));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    n_total++; if (push_fail != 0) $display("FAIL rand_push: got %0d stalled pushes want 0", push_fail); else n_pass++;
    repeat (400) @(negedge clk);
    perr = 0; lerr = 0; nsof = 0;
    foreach (beats[i]) begin
      if (beats[i][8] !== ~^beats[i][7:0]) perr++;
      if (beats[i][10:9] == 2'b00 && beats[i][7:0] != 8'h00) perr++;
      if (beats[i][11] !== 1'b1) lerr++;
      if (beats[i][10:9] == 2'b01) nsof++;
      if (beats[i][10:9] != 2'b00) got.push_back(beats[i][10:0]);
    end
    n_total++; if (perr != 0) $display("FAIL rand_parity: got %0d bad beats want 0", perr); else n_pass++;
    n_total++; if (lerr != 0) $display("FAIL rand_lock: got %0d unlocked beats want 0", lerr); else n_pass++;
    n_total++; if (nsof != 40) $display("FAIL rand_sof_count: got %0d want 40", nsof); else n_pass++;
    n_total++;
    if (got.size() != exp.size()) begin
      $display("FAIL rand_count: got %0d beats want %0d", got.size(), exp.size());
    end else begin
      n_pass++;
      mism = 0;
      foreach (exp[i]) if (got[i] !== exp[i]) mism++;
      n_total++; if (mism != 0) $display("FAIL rand_stream: got %0d wrong beats want 0", mism); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    bit ok0, ok1, seen;
    int bad;
    push_pixel(16'h1234, 1'b0, ok0);
    push_pixel(16'h5678, 1'b0, ok1);
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (lif.link_data_out === 11'h512) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_total++; if (!(seen && ok0 && ok1)) $display("FAIL rmid_hi_seen: got seen %b pushes %b%b want 111", seen, ok0, ok1); else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_total++; if (lif.link_data_out !== 11'h100) $display("FAIL rmid_data: got %h want 100", lif.link_data_out); else n_pass++;
    n_total++; if (lif.link_clk_out !== 1'b0) $display("FAIL rmid_lclk: got %b want 0", lif.link_clk_out); else n_pass++;
    n_total++; if (lif.link_lock_out !== 1'b0) $display("FAIL rmid_lock: got %b want 0", lif.link_lock_out); else n_pass++;
    n_total++; if (lif.ready_out !== 1'b0) $display("FAIL rmid_ready: got %b want 0", lif.ready_out); else n_pass++;
    beats.delete();
    for (int c = 0; c < 500 && beats.size() < 37; c++) @(negedge clk);
    n_total++;
    if (beats.size() < 37) begin
      $display("FAIL rmid_timeout: got %0d beats want 37", beats.size());
    end else begin
      n_pass++;
      bad = 0;
      for (int i = 0; i < 32; i++) if (beats[i] !== 12'h100) bad++;
      n_total++; if (bad != 0) $display("FAIL rmid_train: got %0d bad beats want 0", bad); else n_pass++;
      bad = 0;
      for (int i = 32; i < 37; i++) if (beats[i] !== 12'h900) bad++;
      n_total++; if (bad != 0) $display("FAIL rmid_flush: got %0d non-idle locked beats want 0", bad); else n_pass++;
    end
  endtask

  initial begin
    lif.valid_in = 1'b0;
    lif.pixel_in = 16'h0000;
    lif.sof_in   = 1'b0;
    test_reset();
    test_frame();
    test_latency();
    test_full();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks so far", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
